bias_fc1_reader: RTL and testbench

//  Read-side controller for the FC1 bias ROM. On start it walks all bias batches: drives the ROM address/enable,

---
 rtl/bias_fc1_reader.sv | 181 ++++++++++++++++++
 tb/tb_bias_fc1_reader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_fc1_reader.sv
// Read-side controller for the FC1 bias ROM: fetches one packed batch word per read and
// streams its lanes as sign-extended beats, keeping one batch prefetched to avoid bubbles.
module bias_fc1_reader #(
  parameter int N_BATCH = 4,
  parameter int N_LANE  = 16,
  parameter int W_BIAS  = 34,
  parameter int W_OUT   = 40,
  parameter int W_ADDR  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [W_ADDR-1:0]         rom_aa,
  output logic                      rom_cena,
  input  logic [W_BIAS*N_LANE-1:0]  rom_qa,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [W_OUT-1:0]          m_data,
  output logic [W_ADDR-1:0]         m_batch,
  output logic [$clog2(N_LANE)-1:0] m_lane,
  output logic                      m_last
);

  // state    | meaning
  // S_IDLE   | no pass running, waiting for start
  // S_FILL   | read of batch 0 issued, waiting for it to land in the active word
  // S_STREAM | serializing lanes; further batches are prefetched behind the active word
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam int                W_LANE    = $clog2(N_LANE);
  localparam int                W_WORD    = W_BIAS * N_LANE;
  localparam logic [W_ADDR:0]   RD_TOTAL  = (W_ADDR+1)'(N_BATCH);
  localparam logic [W_ADDR-1:0] BATCH_MAX = W_ADDR'(N_BATCH - 1);
  localparam logic [W_LANE-1:0] LANE_MAX  = W_LANE'(N_LANE - 1);
  localparam logic [W_LANE-1:0] LANE_PEN  = W_LANE'(N_LANE - 2);

  logic [1:0]        r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_rom_cena;
  logic [W_ADDR-1:0] r_rom_aa;
  logic [W_ADDR:0]   r_rd_cnt;
  logic              r_cap;
  logic [W_WORD-1:0] r_act_word;
  logic              r_act_vld;
  logic [W_ADDR-1:0] r_batch;
  logic [W_LANE-1:0] r_lane;
  logic              r_last;
  logic [W_WORD-1:0] r_pf_word;
  logic              r_pf_vld;
  logic [W_ADDR-1:0] r_pf_batch;

  logic                     w_fire;
  logic                     w_lane_end;
  logic                     w_pass_end;
  logic                     w_cap_to_act;
  logic                     w_cap_to_pf;
  logic                     w_issue;
  logic                     w_adv_last;
  logic                     w_pf_last;
  logic                     w_cap_last;
  logic signed [W_BIAS-1:0] w_lane_top;

  assign w_fire     = r_act_vld && m_ready;
  assign w_lane_end = w_fire && (r_lane == LANE_MAX);
  assign w_pass_end = w_fire && r_last;

  // r_cap marks the cycle in which rom_qa carries the word read one cycle earlier.
  // It goes straight to the active word when that word is empty or just finished.
  assign w_cap_to_act = r_cap && (!r_act_vld || (w_lane_end && !r_pf_vld));
  assign w_cap_to_pf  = r_cap && !w_cap_to_act;

  // A new read only goes out once its landing slot is guaranteed free.
  assign w_issue = r_busy && r_rom_cena && !r_cap && !r_pf_vld && (r_rd_cnt < RD_TOTAL);

  assign w_adv_last = (r_batch == BATCH_MAX) && (N_LANE > 1) && (r_lane == LANE_PEN);
  assign w_pf_last  = (r_pf_batch == BATCH_MAX) && (N_LANE == 1);
  assign w_cap_last = (r_rom_aa == BATCH_MAX) && (N_LANE == 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rom_cena <= 1'b1;
      r_rom_aa   <= '0;
      r_rd_cnt   <= '0;
      r_cap      <= 1'b0;
      r_act_word <= '0;
      r_act_vld  <= 1'b0;
      r_batch    <= '0;
      r_lane     <= '0;
      r_last     <= 1'b0;
      r_pf_word  <= '0;
      r_pf_vld   <= 1'b0;
      r_pf_batch <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rom_cena <= 1'b1;
      r_cap      <= !r_rom_cena;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FILL;
            r_busy     <= 1'b1;
            r_rom_cena <= 1'b0;
            r_rom_aa   <= '0;
            r_rd_cnt   <= (W_ADDR+1)'(1);
          end
        end
        S_FILL: begin
          if (w_cap_to_act) r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_pass_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        r_rom_cena <= 1'b0;
        r_rom_aa   <= r_rd_cnt[W_ADDR-1:0];
        r_rd_cnt   <= r_rd_cnt + 1'b1;
      end

      // Active word: lane 0 sits in the MSBs, so each accepted beat shifts the next lane up.
      if (w_pass_end) begin
        r_act_vld <= 1'b0;
        r_last    <= 1'b0;
      end else if (w_lane_end && r_pf_vld) begin
        r_act_word <= r_pf_word;
        r_batch    <= r_pf_batch;
        r_lane     <= '0;
        r_last     <= w_pf_last;
        r_act_vld  <= 1'b1;
      end else if (w_cap_to_act) begin
        r_act_word <= rom_qa;
        r_batch    <= r_rom_aa;
        r_lane     <= '0;
        r_last     <= w_cap_last;
        r_act_vld  <= 1'b1;
      end else if (w_lane_end) begin
        r_act_vld <= 1'b0;
      end else if (w_fire) begin
        r_act_word <= r_act_word << W_BIAS;
        r_lane     <= r_lane + 1'b1;
        r_last     <= w_adv_last;
      end

      if (w_cap_to_pf) begin
        r_pf_word  <= rom_qa;
        r_pf_batch <= r_rom_aa;
        r_pf_vld   <= 1'b1;
      end else if (w_lane_end && r_pf_vld) begin
        r_pf_vld <= 1'b0;
      end
    end
  end

  assign w_lane_top = r_act_word[W_WORD-1 -: W_BIAS];

  assign busy     = r_busy;
  assign done     = r_done;
  assign rom_aa   = r_rom_aa;
  assign rom_cena = r_rom_cena;
  assign m_valid  = r_act_vld;
  assign m_data   = W_OUT'(w_lane_top);
  assign m_batch  = r_batch;
  assign m_lane   = r_lane;
  assign m_last   = r_last;

endmodule

// File: tb/tb_bias_fc1_reader.sv
// Bench for bias_fc1_reader: registered ROM model, expected-beat model derived from the
// ROM contents, a per-cycle monitor, and directed scenarios with literal pins.
module tb_bias_fc1_reader;
  localparam int N_BATCH = 4;
  localparam int N_LANE  = 16;
  localparam int W_BIAS  = 34;
  localparam int W_OUT   = 40;
  localparam int W_ADDR  = 3;
  localparam int W_LANE  = 4;
  localparam int N_BEATS = N_BATCH * N_LANE;
  localparam int W_WORD  = W_BIAS * N_LANE;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [W_ADDR-1:0] rom_aa;
  logic              rom_cena;
  logic [W_WORD-1:0] rom_qa;
  logic              m_valid;
  logic              m_ready;
  logic [W_OUT-1:0]  m_data;
  logic [W_ADDR-1:0] m_batch;
  logic [W_LANE-1:0] m_lane;
  logic              m_last;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bias_fc1_reader #(
    .N_BATCH(N_BATCH), .N_LANE(N_LANE), .W_BIAS(W_BIAS), .W_OUT(W_OUT), .W_ADDR(W_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_aa(rom_aa), .rom_cena(rom_cena), .rom_qa(rom_qa),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_batch(m_batch), .m_lane(m_lane), .m_last(m_last)
  );

  function automatic longint rom_val(int b, int l);
    longint v;
    if (b == 0 && l == 0)  return -64'sd43163716;
    if (b == 0 && l == 1)  return 64'sd170595872;
    if (b == 1 && l == 2)  return 64'sd753293504;
    if (b == 3 && l == 15) return -64'sd32233150;
    if (b == 2 && l == 7)  return -(64'sd1 <<< 33);
    if (b == 2 && l == 8)  return (64'sd1 <<< 33) - 1;
    v = longint'(b * N_LANE + l + 1) * 104729 + 5000;
    if (l % 2 == 1) v = -v;
    return v;
  endfunction

  function automatic logic [W_OUT-1:0] exp_beat(int idx);
    return W_OUT'(rom_val(idx / N_LANE, idx % N_LANE));
  endfunction

  logic [W_WORD-1:0] rom_mem [8];
  initial begin
    for (int b = 0; b < 8; b++)
      for (int l = 0; l < N_LANE; l++)
        rom_mem[b][(N_LANE-l)*W_BIAS-1 -: W_BIAS] = W_BIAS'(rom_val(b, l));
  end

  // Registered ROM; output is junk except in the cycle after an enabled read.
  always @(posedge clk) begin
    if (!rom_cena) rom_qa <= rom_mem[rom_aa];
    else           rom_qa <= {(W_WORD/32){$urandom()}};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  busy,     1'b0);
    chk({tag, "_done"},  done,     1'b0);
    chk({tag, "_cena"},  rom_cena, 1'b1);
    chk({tag, "_aa"},    rom_aa,   '0);
    chk({tag, "_valid"}, m_valid,  1'b0);
    chk({tag, "_data"},  m_data,   '0);
    chk({tag, "_batch"}, m_batch,  '0);
    chk({tag, "_lane"},  m_lane,   '0);
    chk({tag, "_last"},  m_last,   1'b0);
  endtask

  // Per-cycle monitor: model state describes what the DUT must show this cycle.
  bit               mon_en = 1'b0;
  bit               mdl_busy = 1'b0;
  bit               mdl_done = 1'b0;
  int               mdl_beat = 0;
  int               mdl_rd = 0;
  bit               hold = 1'b0;
  bit               prev_cena = 1'b1;
  logic [W_OUT-1:0] held_data;
  logic [W_ADDR-1:0] held_batch;
  logic [W_LANE-1:0] held_lane;
  logic             held_last;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_done", done, mdl_done);
      chk("mon_busy", busy, mdl_busy);
      if (!mdl_busy) chk("mon_idle_valid", m_valid, 1'b0);
      if (hold) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data",  m_data,  held_data);
        chk("stall_batch", m_batch, held_batch);
        chk("stall_lane",  m_lane,  held_lane);
        chk("stall_last",  m_last,  held_last);
      end
      if (m_valid) begin
        if (mdl_beat < N_BEATS) begin
          chk("beat_data",  m_data,  exp_beat(mdl_beat));
          chk("beat_batch", m_batch, mdl_beat / N_LANE);
          chk("beat_lane",  m_lane,  mdl_beat % N_LANE);
          chk("beat_last",  m_last,  mdl_beat == N_BEATS - 1);
        end else begin
          chk("beat_overrun", mdl_beat, N_BEATS - 1);
        end
      end
      if (!rom_cena) begin
        chk("rd_addr",   rom_aa,    mdl_rd);
        chk("rd_count",  mdl_rd < N_BATCH, 1'b1);
        chk("rd_single", prev_cena, 1'b1);
      end
      if (rst) begin
        mdl_busy = 1'b0;
        mdl_done = 1'b0;
        mdl_beat = 0;
        mdl_rd   = 0;
        hold     = 1'b0;
      end else begin
        mdl_done = 1'b0;
        if (!rom_cena) mdl_rd++;
        hold       = m_valid && !m_ready;
        held_data  = m_data;
        held_batch = m_batch;
        held_lane  = m_lane;
        held_last  = m_last;
        if (m_valid && m_ready) begin
          mdl_beat++;
          if (mdl_beat == N_BEATS) begin
            chk("reads_per_pass", mdl_rd, N_BATCH);
            mdl_done = 1'b1;
            mdl_busy = 1'b0;
          end
        end else if (!mdl_busy && start) begin
          mdl_busy = 1'b1;
          mdl_beat = 0;
          mdl_rd   = 0;
        end
      end
      prev_cena = rst ? 1'b1 : rom_cena;
    end
  end

  // Runs one pass from the start pulse; returns on the done cycle (posedge+1) with start low.
  task automatic run_pass(input int rmode, input bit poke, output int hs);
    int cyc;
    hs  = 0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && cyc < 2000) begin
      m_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = poke && (cyc == 10 || cyc == 11 || cyc == 40);
      if (m_valid && m_ready) hs++;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("pass_done_seen", done, 1'b1);
  endtask

  initial begin
    int hs;
    int rd;
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Latency, literal beat values and back-to-back streaming with m_ready high.
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_cena",  rom_cena, 1'b0);
    chk("c1_aa",    rom_aa,   3'd0);
    chk("c1_valid", m_valid,  1'b0);
    chk("c1_busy",  busy,     1'b1);
    tick();
    chk("c2_valid", m_valid, 1'b0);
    tick();
    chk("c3_valid", m_valid, 1'b1);
    chk("b0l0_data", m_data, 40'hFF_FD6D_5FBC);
    chk("b0l0_batch", m_batch, 3'd0);
    chk("b0l0_lane", m_lane, 4'd0);
    for (int i = 1; i < N_BEATS; i++) begin
      tick();
      chk("consecutive_valid", m_valid, 1'b1);
      if (i == 1) chk("b0l1_data", m_data, 40'd170595872);
      if (i == 18) begin
        chk("b1l2_data",  m_data,  40'd753293504);
        chk("b1l2_batch", m_batch, 3'd1);
        chk("b1l2_lane",  m_lane,  4'd2);
      end
      if (i == N_BEATS - 1) begin
        chk("b3l15_data",  m_data,  40'hFF_FE14_2942);
        chk("b3l15_last",  m_last,  1'b1);
        chk("b3l15_batch", m_batch, 3'd3);
        chk("b3l15_lane",  m_lane,  4'd15);
      end
    end
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_busy",  busy, 1'b0);
    chk("done_valid", m_valid, 1'b0);
    tick();
    chk("done_one_cycle", done, 1'b0);
    tick();

    // Random backpressure.
    run_pass(1, 1'b0, hs);
    chk("random_beats", hs, N_BEATS);
    tick();

    // Long stall right after the first valid: only active + prefetch reads go out.
    m_ready = 1'b0;
    rd = 0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_valid !== 1'b1 && cyc < 10) begin
      if (rom_cena == 1'b0) rd++;
      tick();
      cyc++;
    end
    chk("stall_first_valid", m_valid, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (rom_cena == 1'b0) rd++;
      tick();
    end
    chk("stall_reads", rd, 2);
    chk("stall_cena_high", rom_cena, 1'b1);
    chk("stall_still_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("stall_pass_done", done, 1'b1);
    tick();

    // Reset in the middle of a pass, then a clean restart.
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(m_valid === 1'b1 && m_batch == 3'd1 && m_lane == 4'd4) && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("beat20_reached", m_valid && m_batch == 3'd1 && m_lane == 4'd4, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midreset");
    tick();
    chk("midreset_idle_valid", m_valid, 1'b0);
    chk("midreset_idle_cena", rom_cena, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("restart_valid", m_valid, 1'b1);
    chk("restart_data", m_data, 40'hFF_FD6D_5FBC);
    chk("restart_lane", m_lane, 4'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("restart_done", done, 1'b1);
    tick();

    // Start pulses while busy are ignored; start on the done cycle begins a new pass.
    run_pass(0, 1'b1, hs);
    chk("poke_beats", hs, N_BEATS);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("redo_busy",   busy,    1'b1);
    chk("redo_valid1", m_valid, 1'b0);
    tick();
    chk("redo_valid2", m_valid, 1'b0);
    tick();
    chk("redo_valid3", m_valid, 1'b1);
    chk("redo_batch",  m_batch, 3'd0);
    chk("redo_lane",   m_lane,  4'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("redo_done", done, 1'b1);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
